cmp_sequencer: RTL
==================

CMP_SEQUENCER -- requirements
Module: cmp_sequencer

Interface
REQ-001 The block SHALL take parameter NBYTES, default 4, giving the number of operand bytes compared per operation (legal range 2..16).
REQ-002 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to compare A and B, sampled only in IDLE.
REQ-006 A  input  8*NBYTES  first operand, unsigned.
REQ-007 B  input  8*NBYTES  second operand, unsigned.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse, high in the DONE state.
REQ-010 lt / eq / gt  output  1 each  registered result, A<B / A==B / A>B.
REQ-011 err  output  1  registered; set when any captured comparator result was not one-hot.
REQ-012 cmp_a, cmp_b  output  8 each  byte operands driven to the shared 8-bit comparator.
REQ-013 cmp_l, cmp_e, cmp_g  output  1 each  cascade inputs driven to the comparator.
REQ-014 cmp_lt, cmp_eq, cmp_gt  input  1 each  comparator outputs.

Function
REQ-015 The attached comparator SHALL be purely combinational; it resolves byte inequality itself and passes l/e/g through to lt/eq/gt when the bytes are equal.
REQ-016 States SHALL be IDLE, RUN and DONE, with a byte index idx of width ceil(log2(NBYTES)).
REQ-017 In IDLE with start=1 at an edge: latch A and B, set idx=0, set cascade register {l,e,g}=3'b010, clear the internal error flag, go to RUN.
REQ-018 In RUN: cmp_a = A_lat byte idx, cmp_b = B_lat byte idx, {cmp_l,cmp_e,cmp_g} = cascade register; byte 0 is the least significant byte.
REQ-019 At each RUN edge: cascade register <= {cmp_lt,cmp_eq,cmp_gt}; internal error flag |= (captured value not one-hot); idx <= idx+1.
REQ-020 At the RUN edge with idx==NBYTES-1: capture as in REQ-019, load lt/eq/gt from the captured value and err from the updated error flag, go to DONE.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-022 Latency: start sampled at edge k; done high in the cycle after edge k+NBYTES; next start accepted at edge k+NBYTES+2.
REQ-023 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both are Moore outputs.
REQ-024 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-025 Changes on A/B after the start edge SHALL NOT affect the running result.
REQ-026 lt/eq/gt/err SHALL hold their last values until the next REQ-020 update.
REQ-027 In IDLE and DONE: cmp_a=cmp_b=8'h00 and {cmp_l,cmp_e,cmp_g}=3'b010.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, idx=0, busy=0, done=0, lt=eq=gt=0, err=0, latched operands=0, cascade register=3'b010.
REQ-029 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL run normally.

Verification (NBYTES=4, comparator8 attached)
REQ-030 A=B=32'h12345678, start -> busy for 4 cycles, done pulse, eq=1 lt=0 gt=0 err=0.
REQ-031 A=32'h01000000, B=32'h00FFFFFF -> gt=1, because the MSB decision overrides lower-byte lt results.
REQ-032 A=32'h000000FF, B=32'h00000100 -> lt=1; A=32'h00000002, B=32'h00000001 -> gt=1.
REQ-033 Start a comparison, then change A/B and pulse start during RUN -> single done pulse; result from the original operands.
REQ-034 Assert rst 2 cycles into RUN -> all outputs 0 at once, no done pulse; restart with A=B=0 -> eq=1.
REQ-035 Comparator model forced to return 3'b000 for one byte -> err=1 together with done; cleared on next start.

Source files
------------

// File: rtl/cmp_sequencer.sv
// Byte-serial magnitude comparator sequencer: walks NBYTES operand bytes, LSB first,
// through one shared 8-bit cascadable comparator and registers lt/eq/gt/err.
module cmp_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic                  lt,
    output logic                  eq,
    output logic                  gt,
    output logic                  err,
    output logic [7:0]            cmp_a,
    output logic [7:0]            cmp_b,
    output logic                  cmp_l,
    output logic                  cmp_e,
    output logic                  cmp_g,
    input  logic                  cmp_lt,
    input  logic                  cmp_eq,
    input  logic                  cmp_gt
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = $clog2(NBYTES);
    localparam int unsigned LAST  = NBYTES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a_lat;
    logic [W-1:0]       r_b_lat;
    logic [2:0]         r_casc;
    logic               r_err_flag;
    logic [2:0]         r_res;
    logic               r_err;

    logic [2:0]         w_cap;
    logic               w_err_upd;
    logic               w_last;

    assign w_cap     = {cmp_lt, cmp_eq, cmp_gt};
    assign w_err_upd = r_err_flag | ~$onehot(w_cap);
    assign w_last    = (r_idx == IDX_W'(LAST));

    assign lt  = r_res[2];
    assign eq  = r_res[1];
    assign gt  = r_res[0];
    assign err = r_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore outputs; comparator sees a neutral "equal" cascade when idle
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        cmp_a  = 8'h00;
        cmp_b  = 8'h00;
        {cmp_l, cmp_e, cmp_g} = 3'b010;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                cmp_a = r_a_lat[{r_idx, 3'b000} +: 8];
                cmp_b = r_b_lat[{r_idx, 3'b000} +: 8];
                {cmp_l, cmp_e, cmp_g} = r_casc;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, byte index, cascade capture and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_a_lat    <= '0;
            r_b_lat    <= '0;
            r_casc     <= 3'b010;
            r_err_flag <= 1'b0;
            r_res      <= 3'b000;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_lat    <= A;
                        r_b_lat    <= B;
                        r_idx      <= '0;
                        r_casc     <= 3'b010;
                        r_err_flag <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_casc     <= w_cap;
                    r_err_flag <= w_err_upd;
                    r_idx      <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_res <= w_cap;
                        r_err <= w_err_upd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
